// File: rtl/demux_pkg.sv
// Shared types and widths for the demux scan sequencer.
// Holds the FSM/mode encodings and the scan-range advance rule.
package demux_pkg;

    localparam int CH_W  = 5;
    localparam int DIV_W = 24;
    localparam int PH_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        DWELL
    } state_e;

    typedef enum logic {
        MANUAL,
        SCAN
    } mode_e;

    // Next channel of a scan range; the 5-bit add wraps 31 -> 0 so first > last is legal.
    function automatic logic [CH_W-1:0] scan_next(input logic [CH_W-1:0] cur,
                                                  input logic [CH_W-1:0] first,
                                                  input logic [CH_W-1:0] last);
        return (cur == last) ? first : cur + CH_W'(1);
    endfunction

endpackage

// File: rtl/demux_phase_timer.sv
// Loadable down-counter timing one strobe phase (SETUP, WRITE or HOLD).
// done is high once the loaded number of cycles has elapsed.
module demux_phase_timer
    import demux_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PH_W-1:0] load_val,
    output logic            done
);

    logic [PH_W-1:0] cnt_q;
    logic [PH_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val - PH_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/demux_scan_sequencer.sv
// Break-before-make sequencer for the 32-channel analog demux bus, shared
// between a priority host request port and an internal auto-scan engine.
module demux_scan_sequencer
    import demux_pkg::*;
#(
    parameter logic [DIV_W-1:0] CLK_DIVIDER = 24'd10000000,
    parameter logic [PH_W-1:0]  SETUP_CYC   = 4'd2,
    parameter logic [PH_W-1:0]  WR_CYC      = 4'd2,
    parameter logic [PH_W-1:0]  HOLD_CYC    = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_en,
    input  logic [CH_W-1:0] scan_first,
    input  logic [CH_W-1:0] scan_last,
    input  logic            req_valid,
    input  logic [CH_W-1:0] req_ch,
    output logic            req_ready,
    output logic            ena,
    output logic            wr,
    output logic            cs,
    output logic [CH_W-1:0] set_ch,
    output logic [CH_W-1:0] cur_ch,
    output logic            ch_valid,
    output logic            busy
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [DIV_W-1:0] dwell_base;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]  target;
    logic             ena_q, ena_d;
    logic             wr_q, wr_d;
    logic             cs_q, cs_d;
    logic             ch_valid_q, ch_valid_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;
    logic             accept;
    logic             launch;
    logic             tmr_load;
    logic [PH_W-1:0]  tmr_val;
    logic             tmr_done;

    demux_phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dwell_d    = dwell_q;
        dwell_base = dwell_q;
        cur_ch_d   = cur_ch_q;
        target     = cur_ch_q;
        launch     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = SETUP_CYC;
        accept     = req_valid && req_ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    launch = 1'b1;
                    target = req_ch;
                    mode_d = MANUAL;
                end else if (scan_en) begin
                    launch = 1'b1;
                    target = scan_first;
                    mode_d = SCAN;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d  = WRITE;
                    tmr_load = 1'b1;
                    tmr_val  = WR_CYC;
                end
            end
            WRITE: begin
                if (tmr_done) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_CYC;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_d = DWELL;
                    dwell_d = '0;
                end
            end
            DWELL: begin
                // A manual channel picked up by scan restarts its dwell count from zero.
                dwell_base = (mode_q == MANUAL) ? '0 : dwell_q;
                if (accept) begin
                    launch = 1'b1;
                    target = req_ch;
                    mode_d = MANUAL;
                end else if (scan_en) begin
                    mode_d = SCAN;
                    if (dwell_base == CLK_DIVIDER - DIV_W'(1)) begin
                        launch = 1'b1;
                        target = scan_next(cur_ch_q, scan_first, scan_last);
                    end else begin
                        dwell_d = dwell_base + DIV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d  = SETUP;
            cur_ch_d = target;
            tmr_load = 1'b1;
            tmr_val  = SETUP_CYC;
        end

        ena_d       = (state_d == DWELL);
        wr_d        = (state_d == WRITE);
        busy_d      = (state_d == SETUP) || (state_d == WRITE) || (state_d == HOLD);
        cs_d        = busy_d;
        ch_valid_d  = (state_d == DWELL) && (state_q != DWELL);
        req_ready_d = (state_d == IDLE) || (state_d == DWELL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MANUAL;
            dwell_q     <= '0;
            cur_ch_q    <= '0;
            ena_q       <= 1'b0;
            wr_q        <= 1'b0;
            cs_q        <= 1'b0;
            ch_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            cur_ch_q    <= cur_ch_d;
            ena_q       <= ena_d;
            wr_q        <= wr_d;
            cs_q        <= cs_d;
            ch_valid_q  <= ch_valid_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign ena       = ena_q;
    assign wr        = wr_q;
    assign cs        = cs_q;
    assign set_ch    = cur_ch_q;
    assign cur_ch    = cur_ch_q;
    assign ch_valid  = ch_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Scoreboard bench for demux_scan_sequencer: expected channel latches are queued
// by the stimulus and checked by a monitor on each ch_valid pulse.
module tb_demux_scan_sequencer;

    typedef struct {
        int ch;
        int dwell;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic [4:0] scan_first = 5'd0;
    logic [4:0] scan_last = 5'd0;
    logic       req_valid = 1'b0;
    logic [4:0] req_ch = 5'd0;
    logic       req_ready;
    logic       ena;
    logic       wr;
    logic       cs;
    logic [4:0] set_ch;
    logic [4:0] cur_ch;
    logic       ch_valid;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    demux_scan_sequencer #(
        .CLK_DIVIDER (24'd8),
        .SETUP_CYC   (4'd2),
        .WR_CYC      (4'd2),
        .HOLD_CYC    (4'd1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .scan_first (scan_first),
        .scan_last  (scan_last),
        .req_valid  (req_valid),
        .req_ch     (req_ch),
        .req_ready  (req_ready),
        .ena        (ena),
        .wr         (wr),
        .cs         (cs),
        .set_ch     (set_ch),
        .cur_ch     (cur_ch),
        .ch_valid   (ch_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference scan order: after the last channel go back to the first, else step mod 32.
    function automatic int model_next(input int c, input int f, input int l);
        if (c == l) return f;
        return (c + 1) % 32;
    endfunction

    function automatic exp_t mk(input int ch, input int dwell);
        exp_t e;
        e.ch = ch;
        e.dwell = dwell;
        return e;
    endfunction

    // Monitor: protocol invariants every cycle, queued channel on each ch_valid, ena run length.
    int run_len = 0;
    int exp_dwell = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            check_eq("break_before_make", int'(ena && cs), 0);
            check_eq("wr_inside_cs", int'(wr && !cs), 0);
        end
        if (ena) begin
            run_len++;
        end else begin
            if (exp_dwell != 0) check_eq("dwell_len", run_len, exp_dwell);
            exp_dwell = 0;
            run_len = 0;
        end
        if (ch_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ch_valid_ch", int'(cur_ch), -1);
            end else begin
                e = exp_q.pop_front();
                check_eq("latched_cur_ch", int'(cur_ch), e.ch);
                check_eq("latched_set_ch", int'(set_ch), e.ch);
                check_eq("ena_at_ch_valid", int'(ena), 1);
                exp_dwell = e.dwell;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        scan_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_req(input logic [4:0] ch);
        int n = 0;
        req_valid = 1'b1;
        req_ch = ch;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_accept_in_time", int'(n < 100), 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_wr(input string name);
        int n = 0;
        while (!wr && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(name, int'(wr), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rc;
        int c;
        int f;
        int l;
        int k;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_ena", int'(ena), 0);
        check_eq("rst_wr", int'(wr), 0);
        check_eq("rst_cs", int'(cs), 0);
        check_eq("rst_set_ch", int'(set_ch), 0);
        check_eq("rst_req_ready", int'(req_ready), 0);
        check_eq("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("req_ready_after_rst", int'(req_ready), 1);

        // Host request latency for channel 5
        exp_q.push_back(mk(5, 0));
        host_req(5'd5);
        for (int k2 = 1; k2 <= 6; k2++) begin
            check_eq($sformatf("lat%0d_cs", k2), int'(cs), int'(k2 <= 5));
            check_eq($sformatf("lat%0d_wr", k2), int'(wr), int'(k2 == 3 || k2 == 4));
            check_eq($sformatf("lat%0d_ena", k2), int'(ena), int'(k2 == 6));
            check_eq($sformatf("lat%0d_ch_valid", k2), int'(ch_valid), int'(k2 == 6));
            check_eq($sformatf("lat%0d_req_ready", k2), int'(req_ready), int'(k2 == 6));
            check_eq($sformatf("lat%0d_busy", k2), int'(busy), int'(k2 <= 5));
            check_eq($sformatf("lat%0d_set_ch", k2), int'(set_ch), 5);
            if (k2 < 6) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_eq("manual_hold_ena", int'(ena), 1);
        check_eq("manual_hold_ch", int'(cur_ch), 5);
        wait_drain(10);

        // Wrapping scan range 30..1
        do_reset();
        scan_first = 5'd30;
        scan_last = 5'd1;
        exp_q.push_back(mk(30, 8));
        exp_q.push_back(mk(31, 8));
        exp_q.push_back(mk(0, 8));
        exp_q.push_back(mk(1, 8));
        exp_q.push_back(mk(30, 0));
        scan_en = 1'b1;
        wait_drain(200);
        scan_en = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("scan_frozen_ena", int'(ena), 1);
        check_eq("scan_frozen_ch", int'(cur_ch), 30);

        // Host request collides with scan dwell expiry on channel 3
        do_reset();
        scan_first = 5'd3;
        scan_last = 5'd5;
        exp_q.push_back(mk(3, 8));
        exp_q.push_back(mk(12, 8));
        exp_q.push_back(mk(13, 0));
        scan_en = 1'b1;
        n = 0;
        while (!ch_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("scan_first_latch_seen", int'(ch_valid), 1);
        repeat (7) @(negedge clk);
        req_valid = 1'b1;
        req_ch = 5'd12;
        check_eq("collide_req_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("collide_cs", int'(cs), 1);
        check_eq("collide_set_ch", int'(set_ch), 12);
        wait_drain(100);
        scan_en = 1'b0;

        // Request held while busy, accepted on the first dwell cycle
        do_reset();
        rc = $urandom_range(0, 31);
        exp_q.push_back(mk(12, 1));
        exp_q.push_back(mk(rc, 0));
        host_req(5'd12);
        wait_wr("held_req_wr_seen");
        check_eq("held_req_ready_low", int'(req_ready), 0);
        req_valid = 1'b1;
        req_ch = rc[4:0];
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("held_req_wait_cycles", n, 3);
        check_eq("held_req_at_ch_valid", int'(ch_valid), 1);
        check_eq("held_req_cur_ch", int'(cur_ch), 12);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("held_req_cs", int'(cs), 1);
        check_eq("held_req_set_ch", int'(set_ch), rc);
        wait_drain(50);

        // Reset during WRITE aborts the strobe
        req_valid = 1'b1;
        req_ch = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        wait_wr("abort_wr_seen");
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_wr", int'(wr), 0);
        check_eq("abort_cs", int'(cs), 0);
        check_eq("abort_ena", int'(ena), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_req_ready", int'(req_ready), 0);
        check_eq("abort_cur_ch", int'(cur_ch), 0);
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check_eq("post_abort_no_strobe", int'(wr || cs || ena), 0);
        end
        check_eq("post_abort_req_ready", int'(req_ready), 1);

        // Randomized manual requests followed by scan runs
        for (int it = 0; it < 6; it++) begin
            c = $urandom_range(0, 31);
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            k = $urandom_range(2, 4);
            exp_q.push_back(mk(c, 0));
            host_req(c[4:0]);
            wait_drain(50);
            for (int j = 0; j < k; j++) begin
                c = model_next(c, f, l);
                exp_q.push_back(mk(c, (j == k - 1) ? 0 : 8));
            end
            scan_first = f[4:0];
            scan_last = l[4:0];
            scan_en = 1'b1;
            wait_drain(20 * k + 50);
            scan_en = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
